// File: rtl/shift_rotate_inverse.sv
// Inverse shift/rotate unit: undoes a forward 8-bit shl/shr/rol/ror by N
// (0..7) one bit per clock, and tracks which result bits can be recovered
// exactly.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   start      - begin an inverse operation (accepted in IDLE or DONE)
//   data       - value produced by the forward unit
//   shiftCount - forward shift/rotate count N
//   operation  - forward op to undo: 00 shl, 01 shr, 10 rol, 11 ror
//   busy       - high while bit-steps are in progress (RUN)
//   done       - one-cycle completion pulse (DONE)
//   result     - recovered data, unknown bits forced to 0
//   knownMask  - 1 for each result bit that is exactly recovered
module shift_rotate_inverse (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [2:0] shiftCount,
    input  logic [1:0] operation,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] knownMask
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned OW = 2;

    localparam logic [OW-1:0] OP_SHL = 2'b00;
    localparam logic [OW-1:0] OP_SHR = 2'b01;
    localparam logic [OW-1:0] OP_ROL = 2'b10;
    localparam logic [OW-1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [OW-1:0] op_q, op_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] known_q, known_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, working-register step and output load
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mask_d   = mask_q;
        op_d     = op_q;
        rem_d    = rem_q;
        result_d = result_q;
        known_d  = known_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    data_d  = data;
                    mask_d  = '1;
                    op_d    = operation;
                    rem_d   = shiftCount;
                    state_d = (shiftCount != '0) ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Shifts lose bits (mask follows data); rotates lose nothing
                case (op_q)
                    OP_SHL: begin
                        data_d = {1'b0, data_q[DW-1:1]};
                        mask_d = {1'b0, mask_q[DW-1:1]};
                    end
                    OP_SHR: begin
                        data_d = {data_q[DW-2:0], 1'b0};
                        mask_d = {mask_q[DW-2:0], 1'b0};
                    end
                    OP_ROL:  data_d = {data_q[0], data_q[DW-1:1]};
                    OP_ROR:  data_d = {data_q[DW-2:0], data_q[DW-1]};
                    default: data_d = data_q;
                endcase
                rem_d = CW'(rem_q - CW'(1));
                if (rem_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every entry to DONE (including DONE->DONE for N=0) publishes a result
        if (state_d == DONE) begin
            result_d = data_d;
            known_d  = mask_d;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            result_q <= '0;
            known_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            known_q  <= known_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign knownMask = known_q;

endmodule

// File: tb/tb_shift_rotate_inverse.sv
// Self-checking bench for shift_rotate_inverse: directed operations with a
// scoreboard of expected result/mask/completion-cycle checked on each done.
module tb_shift_rotate_inverse;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [2:0] shiftCount;
    logic [1:0] operation;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] knownMask;

    shift_rotate_inverse dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data       (data),
        .shiftCount (shiftCount),
        .operation  (operation),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .knownMask  (knownMask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic [7:0] mask;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: apply the inverse step n times to data and a full mask
    function automatic logic [15:0] model(input logic [7:0] d, input int n,
                                         input logic [1:0] op);
        logic [7:0] r;
        logic [7:0] m;
        r = d;
        m = 8'hFF;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b00: begin r = r >> 1; m = m >> 1; end
                2'b01: begin r = r << 1; m = m << 1; end
                2'b10: r = {r[0], r[7:1]};
                default: r = {r[6:0], r[7]};
            endcase
        end
        return {r, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected entry for an op whose capture edge is the next posedge
    task automatic push(input logic [7:0] d, input int n, input logic [1:0] op,
                        input int extra);
        logic [15:0] e;
        e = model(d, n, op);
        sb.push_back('{e[15:8], e[7:0], cyc + 1 + n + extra});
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", 32'(result), 32'(e.res));
                chk("sb_mask", 32'(knownMask), 32'(e.mask));
                chk("sb_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    // One op with start for a single cycle; inputs scrambled after capture,
    // optional ignored start pulse mid-RUN (only when n >= 3)
    task automatic run_single(input logic [7:0] d, input int n,
                              input logic [1:0] op);
        logic [15:0] e;
        e          = model(d, n, op);
        data       = d;
        shiftCount = 3'(n);
        operation  = op;
        start      = 1'b1;
        push(d, n, op, 0);
        tick();
        start      = 1'b0;
        data       = 8'($urandom);
        shiftCount = 3'($urandom);
        operation  = 2'($urandom);
        for (int i = 0; i < n; i++) begin
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_done", 32'(done), 32'(0));
            if (i == 1 && n >= 3) begin
                start = 1'b1;
                data  = 8'($urandom);
            end
            if (i == 2) start = 1'b0;
            tick();
        end
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_pulse", 32'(done), 32'(1));
        tick();
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("hold_result", 32'(result), 32'(e[15:8]));
        chk("hold_mask", 32'(knownMask), 32'(e[7:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start asserted: reset wins
        rst        = 1'b1;
        start      = 1'b1;
        data       = 8'hFF;
        shiftCount = 3'd0;
        operation  = 2'b00;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_mask", 32'(knownMask), 32'(0));
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // Directed cases
        run_single(8'hB1, 3, 2'b10);
        chk("b1_result", 32'(result), 32'h36);
        chk("b1_mask", 32'(knownMask), 32'hFF);
        run_single(8'hA8, 3, 2'b00);
        chk("a8_result", 32'(result), 32'h15);
        chk("a8_mask", 32'(knownMask), 32'h1F);
        run_single(8'h15, 2, 2'b01);
        chk("15_result", 32'(result), 32'h54);
        chk("15_mask", 32'(knownMask), 32'hFC);
        run_single(8'h5A, 0, 2'b11);
        chk("5a_result", 32'(result), 32'h5A);
        chk("5a_mask", 32'(knownMask), 32'hFF);
        run_single(8'hC3, 7, 2'b11);
        run_single(8'h9E, 5, 2'b01);
        drain();

        // Back-to-back: start held, new inputs during RUN are ignored,
        // second op captured in the DONE cycle
        data       = 8'h3C;
        shiftCount = 3'd2;
        operation  = 2'b10;
        start      = 1'b1;
        push(8'h3C, 2, 2'b10, 0);
        push(8'hF0, 1, 2'b00, 3);
        tick();
        data       = 8'hF0;
        shiftCount = 3'd1;
        operation  = 2'b00;
        chk("b2b_busy1", 32'(busy), 32'(1));
        tick();
        tick();
        chk("b2b_done_a", 32'(done), 32'(1));
        chk("b2b_result_a", 32'(result), 32'h0F);
        tick();
        start = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'(1));
        tick();
        chk("b2b_result_b", 32'(result), 32'h78);
        chk("b2b_mask_b", 32'(knownMask), 32'h7F);
        drain();

        // Back-to-back N=0 ops: DONE -> DONE
        data       = 8'h11;
        shiftCount = 3'd0;
        operation  = 2'b00;
        start      = 1'b1;
        push(8'h11, 0, 2'b00, 0);
        push(8'h22, 0, 2'b01, 1);
        tick();
        data      = 8'h22;
        operation = 2'b01;
        tick();
        start = 1'b0;
        chk("n0_b2b_done", 32'(done), 32'(1));
        drain();

        // Reset on the 2nd RUN cycle of an N=7 op
        data       = 8'h81;
        shiftCount = 3'd7;
        operation  = 2'b01;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_pre", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_mask", 32'(knownMask), 32'(0));
        rst = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("abort_no_done", 32'(sb.size()), 32'(0));

        // Recovery after abort
        run_single(8'h6D, 4, 2'b00);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_rotate_inverse.md
SHIFT_ROTATE_INVERSE -- requirements
Module: shift_rotate_inverse

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port start, input, 1 bit: request to begin an inverse operation; sampled on the rising edge.
REQ-005 Port data, input, 8 bits: value previously produced by the forward shift/rotate unit.
REQ-006 Port shiftCount, input, 3 bits: count N (0..7) that was used by the forward operation.
REQ-007 Port operation, input, 2 bits: forward op to undo; 00 shl, 01 shr, 10 rol, 11 ror.
REQ-008 Port busy, output, 1 bit: high while bit-steps are in progress.
REQ-009 Port done, output, 1 bit: single-cycle completion pulse.
REQ-010 Port result, output, 8 bits: recovered original data; unknown bits are 0.
REQ-011 Port knownMask, output, 8 bits: 1 marks result bits that are exactly recovered.

Function
REQ-012 State machine SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture data, shiftCount and operation into internal registers; working mask loaded with 0xFF.
REQ-014 On capture, the next state SHALL be RUN with remaining=N if N>0, otherwise DONE.
REQ-015 Each RUN cycle SHALL apply exactly one 1-bit inverse step and decrement remaining.
REQ-016 Inverse steps: op 00 -> logical shift right 1, zero fill; op 01 -> logical shift left 1, zero fill; op 10 -> rotate right 1; op 11 -> rotate left 1.
REQ-017 Working mask SHALL shift with the data for ops 00 and 01 (zero fill) and remain unchanged for ops 10 and 11.
REQ-018 When a RUN step brings remaining from 1 to 0, the next state SHALL be DONE.
REQ-019 On entry to DONE, result and knownMask SHALL load from the working registers.
REQ-020 result and knownMask SHALL then hold until the next entry to DONE.
REQ-021 done SHALL be high for exactly the one cycle spent in DONE.
REQ-022 busy SHALL be high exactly while the state is RUN.
REQ-023 Latency: done SHALL be high after exactly N+1 rising edges counted from and including the edge that sampled start; N=0 gives 1 edge.
REQ-024 start while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-025 start during DONE SHALL be accepted, allowing back-to-back operations with no IDLE cycle.
REQ-026 DONE without a new start SHALL return to IDLE on the next edge.
REQ-027 Input changes after the capture edge SHALL NOT affect the operation in progress.

Reset
REQ-028 rst=1 SHALL force IDLE with busy=0, done=0, result=0x00, knownMask=0x00, and clear all working registers.
REQ-029 rst SHALL take priority over start and SHALL abort any operation in progress; no done pulse SHALL follow.

Verification
REQ-030 Bench SHALL cover: data=0xB1, op=10, N=3, start -> done on 4th edge, result=0x36, knownMask=0xFF, busy high 3 cycles.
REQ-031 Bench SHALL cover: data=0xA8, op=00, N=3 -> result=0x15, knownMask=0x1F.
REQ-032 Bench SHALL cover: data=0x15, op=01, N=2 -> result=0x54, knownMask=0xFC.
REQ-033 Bench SHALL cover: data=0x5A, op=11, N=0 -> done on 1st edge, busy never high, result=0x5A, knownMask=0xFF.
REQ-034 Bench SHALL cover back-to-back and ignored starts: start held continuously with new inputs -> second op captured in the DONE cycle; starts during RUN ignored; each result correct.
REQ-035 Bench SHALL cover reset mid-operation: rst on the 2nd RUN cycle of an N=7 op -> next cycle IDLE, all outputs 0, no done pulse.
